// File: rtl/slice_size_table_reader.sv
// slice_size_table_reader
//   Decoder-side reader for a picture's slice size table. Parses slice_num
//   big-endian 16-bit sizes from a byte stream, stores them in an internal
//   table, keeps a running total, and offers a registered random-access
//   read port for the slice-data fetcher.
//
// Optional feature macro: SLICE_SIZE_ZERO_CHECK_EN
//   defined   -> zero_size_err flags any parsed size of 0x0000 (sticky
//                until the next accepted start)
//   undefined -> zero_size_err tied to 0
//
// Ports:
//   clock, reset_n       rising-edge clock, async active-low reset
//   start, slice_num     start pulse (accepted in IDLE/DONE) and entry count
//   in_valid, in_data    incoming stream byte, MSB first
//   in_ready             byte accepted this cycle (HI/LO states)
//   rd_addr, rd_data     table read port, 1-cycle latency
//   busy, done, error    parse status
//   entry_count          entries written so far
//   total_size           sum of parsed sizes (mod 2^32)
//   zero_size_err        zero-size flag (optional feature)
module slice_size_table_reader #(
    parameter int MAX_SLICES = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       slice_num,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [15:0]       rd_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       entry_count,
    output logic [31:0]       total_size,
    output logic              zero_size_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] n_q, n_d;
    logic [7:0]  hi_q, hi_d;
    logic [31:0] entry_count_q, entry_count_d;
    logic [31:0] total_size_q, total_size_d;
    logic        error_q, error_d;
    logic [15:0] rd_data_q;

    logic              xfer;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] wr_addr;

    logic [15:0] slice_tbl [MAX_SLICES];

`ifdef SLICE_SIZE_ZERO_CHECK_EN
    logic zero_size_err_q, zero_size_err_d;
`endif

    assign in_ready = (state_q == HI) || (state_q == LO);
    assign xfer     = in_valid && in_ready;
    assign wr_data  = {hi_q, in_data};
    assign wr_addr  = entry_count_q[ADDR_W-1:0];

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        hi_d          = hi_q;
        entry_count_d = entry_count_q;
        total_size_d  = total_size_q;
        error_d       = error_q;
        wr_en         = 1'b0;
`ifdef SLICE_SIZE_ZERO_CHECK_EN
        zero_size_err_d = zero_size_err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    n_d           = slice_num;
                    entry_count_d = '0;
                    total_size_d  = '0;
`ifdef SLICE_SIZE_ZERO_CHECK_EN
                    zero_size_err_d = 1'b0;
`endif
                    // Invalid counts go straight to DONE without consuming bytes.
                    if (slice_num == 32'd0 || slice_num > 32'(MAX_SLICES)) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b0;
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    state_d = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    wr_en         = 1'b1;
                    total_size_d  = total_size_q + {16'd0, wr_data};
                    entry_count_d = entry_count_q + 32'd1;
`ifdef SLICE_SIZE_ZERO_CHECK_EN
                    if (wr_data == 16'd0)
                        zero_size_err_d = 1'b1;
`endif
                    state_d = (entry_count_d == n_q) ? DONE : HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            n_q           <= '0;
            hi_q          <= '0;
            entry_count_q <= '0;
            total_size_q  <= '0;
            error_q       <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            hi_q          <= hi_d;
            entry_count_q <= entry_count_d;
            total_size_q  <= total_size_d;
            error_q       <= error_d;
            // Non-blocking read alongside the write gives old data on a
            // same-cycle read/write of one entry.
            rd_data_q     <= slice_tbl[rd_addr];
        end
    end

    // Table storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (wr_en)
            slice_tbl[wr_addr] <= wr_data;
    end

`ifdef SLICE_SIZE_ZERO_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            zero_size_err_q <= 1'b0;
        else
            zero_size_err_q <= zero_size_err_d;
    end
    assign zero_size_err = zero_size_err_q;
`else
    assign zero_size_err = 1'b0;
`endif

    assign rd_data     = rd_data_q;
    assign busy        = in_ready;
    assign done        = (state_q == DONE);
    assign error       = error_q;
    assign entry_count = entry_count_q;
    assign total_size  = total_size_q;

endmodule

// File: tb/tb_slice_size_table_reader.sv
// Testbench for slice_size_table_reader: table-driven parse scenarios plus
// hand-written sequences for reset mid-parse, start while busy, same-cycle
// read/write and the zero-size flag.
module tb_slice_size_table_reader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] slice_num;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] entry_count;
    logic [31:0] total_size;
    logic        zero_size_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    slice_size_table_reader #(.MAX_SLICES(256), .ADDR_W(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .slice_num     (slice_num),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .entry_count   (entry_count),
        .total_size    (total_size),
        .zero_size_err (zero_size_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] n;
        int          nbytes;
        logic [47:0] bytes;
        bit          gap;
        logic [31:0] exp_err;
        logic [31:0] exp_cnt;
        logic [31:0] exp_total;
        int          nrd;
        logic [47:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s got=%h expected=%h", name, got, exp);
    endtask

    task automatic do_start(input logic [31:0] n);
        @(negedge clock);
        start     = 1'b1;
        slice_num = n;
        @(negedge clock);
        start     = 1'b0;
    endtask

    // Called at a negedge; leaves at the negedge after the byte's transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_done"},  {31'd0, done},          32'd0);
        check({tag, "_busy"},  {31'd0, busy},          32'd0);
        check({tag, "_rdy"},   {31'd0, in_ready},      32'd0);
        check({tag, "_err"},   {31'd0, error},         32'd0);
        check({tag, "_cnt"},   entry_count,            32'd0);
        check({tag, "_total"}, total_size,             32'd0);
        check({tag, "_rd"},    {16'd0, rd_data},       32'd0);
        check({tag, "_zero"},  {31'd0, zero_size_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [47:0] bv;
        logic [15:0] ev;
        logic [31:0] exp_zero;

        vecs[0] = '{n: 32'd3,   nbytes: 6, bytes: 48'h0010_0100_FFFE, gap: 1'b0,
                    exp_err: 0, exp_cnt: 32'd3, exp_total: 32'h0001_010E, nrd: 3, exp_rd: 48'h0010_0100_FFFE};
        vecs[1] = '{n: 32'd3,   nbytes: 6, bytes: 48'h0010_0100_FFFE, gap: 1'b1,
                    exp_err: 0, exp_cnt: 32'd3, exp_total: 32'h0001_010E, nrd: 3, exp_rd: 48'h0010_0100_FFFE};
        vecs[2] = '{n: 32'd0,   nbytes: 0, bytes: 48'h0, gap: 1'b0,
                    exp_err: 1, exp_cnt: 32'd0, exp_total: 32'd0, nrd: 0, exp_rd: 48'h0};
        vecs[3] = '{n: 32'd257, nbytes: 0, bytes: 48'h0, gap: 1'b0,
                    exp_err: 1, exp_cnt: 32'd0, exp_total: 32'd0, nrd: 0, exp_rd: 48'h0};
        vecs[4] = '{n: 32'd1,   nbytes: 2, bytes: 48'h1234_0000_0000, gap: 1'b0,
                    exp_err: 0, exp_cnt: 32'd1, exp_total: 32'h0000_1234, nrd: 1, exp_rd: 48'h1234_0000_0000};

        reset_n   = 1'b0;
        start     = 1'b0;
        slice_num = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        rd_addr   = '0;
        #23;
        check_idle_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Table-driven scenarios
        for (int v = 0; v < 5; v++) begin
            do_start(vecs[v].n);
            if (vecs[v].nbytes == 0)
                check($sformatf("v%0d_rdy_never", v), {31'd0, in_ready}, 32'd0);
            else
                check($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
            bv = vecs[v].bytes;
            for (int i = 0; i < vecs[v].nbytes; i++) begin
                send_byte(bv[47 - 8*i -: 8]);
                if (vecs[v].gap && i < vecs[v].nbytes - 1) begin
                    check($sformatf("v%0d_rdy_hold%0d", v, i), {31'd0, in_ready}, 32'd1);
                    @(negedge clock);
                end
            end
            check($sformatf("v%0d_done", v),  {31'd0, done},  32'd1);
            check($sformatf("v%0d_rdy", v),   {31'd0, in_ready}, 32'd0);
            check($sformatf("v%0d_err", v),   {31'd0, error}, vecs[v].exp_err);
            check($sformatf("v%0d_cnt", v),   entry_count,    vecs[v].exp_cnt);
            check($sformatf("v%0d_total", v), total_size,     vecs[v].exp_total);
            bv = vecs[v].exp_rd;
            for (int r = 0; r < vecs[v].nrd; r++) begin
                rd_addr = 8'(r);
                @(negedge clock);
                ev = bv[47 - 16*r -: 16];
                check($sformatf("v%0d_rd%0d", v, r), {16'd0, rd_data}, {16'd0, ev});
            end
        end

        // Largest count accepted, then reset mid-parse after 3 bytes
        do_start(32'd256);
        check("max_n_busy", {31'd0, busy},  32'd1);
        check("max_n_err",  {31'd0, error}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h01);
        rd_addr = 8'd1;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        do_start(32'd2);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        check("rst_restart_done",  {31'd0, done}, 32'd1);
        check("rst_restart_total", total_size,    32'd3);
        check("rst_restart_cnt",   entry_count,   32'd2);

        // Start pulse while busy is ignored
        do_start(32'd2);
        send_byte(8'hAB);
        send_byte(8'hCD);
        start     = 1'b1;
        slice_num = 32'd5;
        @(negedge clock);
        start     = 1'b0;
        check("busy_start_ignored", {31'd0, busy}, 32'd1);
        check("busy_start_cnt",     entry_count,   32'd1);
        send_byte(8'h00);
        send_byte(8'h05);
        check("busy_start_done",  {31'd0, done}, 32'd1);
        check("busy_start_cnt2",  entry_count,   32'd2);
        check("busy_start_total", total_size,    32'h0000_ABD2);

        // Zero-size entry with same-cycle read of the entry being written
`ifdef SLICE_SIZE_ZERO_CHECK_EN
        exp_zero = 32'd1;
`else
        exp_zero = 32'd0;
`endif
        do_start(32'd2);
        check("zero_clr", {31'd0, zero_size_err}, 32'd0);
        send_byte(8'h00);
        rd_addr = 8'd0;
        send_byte(8'h00);
        check("rw_same_cycle_old", {16'd0, rd_data}, 32'h0000_ABCD);
        @(negedge clock);
        check("rw_new",           {16'd0, rd_data}, 32'd0);
        check("zero_flag_mid",    {31'd0, zero_size_err}, exp_zero);
        send_byte(8'h00);
        send_byte(8'h08);
        check("zero_done",  {31'd0, done},          32'd1);
        check("zero_total", total_size,             32'd8);
        check("zero_flag",  {31'd0, zero_size_err}, exp_zero);
        do_start(32'd1);
        check("zero_flag_cleared", {31'd0, zero_size_err}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
